// File: rtl/tlul_host_arbiter_pkg.sv
// Local types and helpers for the TL-UL host arbiter.
package tlul_host_arbiter_pkg;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Req  = 2'd1,
    Rsp  = 2'd2
  } arb_state_e;

  // (a + b) mod n for a, b < n; used to walk the request ring from the pointer.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) begin
      s = s - n;
    end else begin
      s = s;
    end
    return s;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel types, opcodes and the idle channel constants that the arbiter,
// test hosts and device shims share.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  // Host-to-device channel with nothing requested and nothing accepted.
  localparam tl_h2d_t TL_H2D_IDLE = '{
    a_valid:   1'b0,
    a_opcode:  PutFullData,
    a_param:   3'h0,
    a_size:    2'h0,
    a_source:  8'h00,
    a_address: 32'h0000_0000,
    a_mask:    4'h0,
    a_data:    32'h0000_0000,
    d_ready:   1'b0
  };

  // Device-to-host channel with no response and no A-channel acceptance.
  localparam tl_d2h_t TL_D2H_IDLE = '{
    d_valid:  1'b0,
    d_opcode: AccessAck,
    d_param:  3'h0,
    d_size:   2'h0,
    d_source: 8'h00,
    d_sink:   1'b0,
    d_data:   32'h0000_0000,
    d_error:  1'b0,
    a_ready:  1'b0
  };

endpackage

// File: rtl/tlul_host_arbiter_if.sv
// Bundles the per-host TL-UL ports and the shared device port of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface tlul_host_arbiter_if
  import tlul_pkg::*;
#(
  parameter int NumHosts = 2
) ();

  tl_h2d_t tl_h_i [NumHosts];
  tl_d2h_t tl_h_o [NumHosts];
  tl_h2d_t tl_d_o;
  tl_d2h_t tl_d_i;

  modport master (
    output tl_h_i,
    output tl_d_i,
    input  tl_h_o,
    input  tl_d_o
  );

  modport slave (
    input  tl_h_i,
    input  tl_d_i,
    output tl_h_o,
    output tl_d_o
  );

endinterface

// File: rtl/tlul_host_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the
// pointer, wrapping around the ring.
module rr_arbiter
  import tlul_host_arbiter_pkg::*;
#(
  parameter int NumHosts = 2,
  localparam int IdxW = $clog2(NumHosts)
) (
  input  logic [NumHosts-1:0] req,
  input  logic [IdxW-1:0]     ptr,
  output logic [NumHosts-1:0] gnt,
  output logic [IdxW-1:0]     idx,
  output logic                any
);

  logic [IdxW-1:0] cand_s;

  // Scan the ring starting at ptr and keep the first requester found.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    for (int i = 0; i < NumHosts; i++) begin
      cand_s = IdxW'(wrap_add(int'(ptr), i, NumHosts));
      if (!any && req[cand_s]) begin
        any         = 1'b1;
        idx         = cand_s;
        gnt[cand_s] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/tlul_host_arbiter.sv
// Shares one TL-UL device port between NumHosts hosts with a single
// outstanding transaction: arbitrate (Idle), forward A (Req), return D (Rsp).
module tlul_host_arbiter
  import tlul_pkg::*;
  import tlul_host_arbiter_pkg::*;
#(
  parameter int NumHosts = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  tlul_host_arbiter_if.slave   bus,
  output logic [NumHosts-1:0]  gnt_o
);

  localparam int IdxW = $clog2(NumHosts);

  arb_state_e          state_r, state_s;
  logic [IdxW-1:0]     idx_r, idx_s;
  logic [IdxW-1:0]     rr_ptr_r, rr_ptr_s;
  logic [NumHosts-1:0] gnt_r, gnt_s;

  logic [NumHosts-1:0] req_s;
  logic [NumHosts-1:0] arb_gnt_s;
  logic [IdxW-1:0]     arb_idx_s;
  logic                arb_any_s;
  tl_h2d_t             sel_h2d_s;

  // Collect A-channel requests and select the granted host's channel.
  always_comb begin
    req_s     = '0;
    sel_h2d_s = TL_H2D_IDLE;
    for (int k = 0; k < NumHosts; k++) begin
      req_s[k] = bus.tl_h_i[k].a_valid;
      if (IdxW'(k) == idx_r) begin
        sel_h2d_s = bus.tl_h_i[k];
      end else begin
        sel_h2d_s = sel_h2d_s;
      end
    end
  end

  rr_arbiter #(
    .NumHosts (NumHosts)
  ) u_rr_arbiter (
    .req (req_s),
    .ptr (rr_ptr_r),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s),
    .any (arb_any_s)
  );

  // Next-state logic: grant in Idle, wait for the A handshake in Req, wait for
  // the D handshake in Rsp and then move the pointer past the served host.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    rr_ptr_s = rr_ptr_r;
    gnt_s    = gnt_r;
    case (state_r)
      Idle: begin
        if (arb_any_s) begin
          state_s = Req;
          idx_s   = arb_idx_s;
          gnt_s   = arb_gnt_s;
        end else begin
          state_s = Idle;
        end
      end
      Req: begin
        // Grant is held even if the host withdraws a_valid.
        if (sel_h2d_s.a_valid && bus.tl_d_i.a_ready) begin
          state_s = Rsp;
        end else begin
          state_s = Req;
        end
      end
      Rsp: begin
        if (bus.tl_d_i.d_valid && sel_h2d_s.d_ready) begin
          state_s  = Idle;
          gnt_s    = '0;
          rr_ptr_s = (idx_r == IdxW'(NumHosts - 1)) ? '0 : idx_r + IdxW'(1);
        end else begin
          state_s = Rsp;
        end
      end
      default: begin
        state_s = Idle;
        gnt_s   = '0;
      end
    endcase
  end

  // State, grant index, owner vector and round-robin pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= Idle;
      idx_r    <= '0;
      rr_ptr_r <= '0;
      gnt_r    <= '0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      rr_ptr_r <= rr_ptr_s;
      gnt_r    <= gnt_s;
    end
  end

  // Channel steering: only the owner ever sees a_ready or d_valid, and the
  // device sees d_ready only while a response is expected.
  always_comb begin
    bus.tl_d_o = TL_H2D_IDLE;
    for (int k = 0; k < NumHosts; k++) begin
      bus.tl_h_o[k] = TL_D2H_IDLE;
    end
    case (state_r)
      Req: begin
        bus.tl_d_o         = sel_h2d_s;
        bus.tl_d_o.d_ready = 1'b0;
        for (int k = 0; k < NumHosts; k++) begin
          if (IdxW'(k) == idx_r) begin
            bus.tl_h_o[k].a_ready = bus.tl_d_i.a_ready;
          end else begin
            bus.tl_h_o[k].a_ready = 1'b0;
          end
        end
      end
      Rsp: begin
        bus.tl_d_o.d_ready = sel_h2d_s.d_ready;
        for (int k = 0; k < NumHosts; k++) begin
          if (IdxW'(k) == idx_r) begin
            bus.tl_h_o[k]         = bus.tl_d_i;
            bus.tl_h_o[k].a_ready = 1'b0;
          end else begin
            bus.tl_h_o[k] = TL_D2H_IDLE;
          end
        end
      end
      default: begin
        bus.tl_d_o = TL_H2D_IDLE;
      end
    endcase
  end

  assign gnt_o = gnt_r;

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Scoreboard bench for tlul_host_arbiter with three hosts and a small memory
// device model. Expected A beats and D responses are queued when each
// transaction is issued; a monitor pops and compares on every handshake.
module tb_tlul_host_arbiter;
  import tlul_pkg::*;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic [N-1:0] gnt;

  always #10 clk = ~clk;

  tlul_host_arbiter_if #(.NumHosts(N)) bus ();

  tlul_host_arbiter #(.NumHosts(N)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus),
    .gnt_o  (gnt)
  );

  typedef struct {
    int          host;
    tl_a_op_e    op;
    logic [31:0] addr;
    logic [31:0] wdata;
    tl_d_op_e    dop;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_d[$];
  exp_t mon_e;
  logic [N-1:0] mon_oh;

  int total = 0;
  int bad = 0;
  int a_hs_cnt = 0;
  int av_cycles = 0;
  logic dev_ar = 1'b1;

  logic [31:0] mem [logic [31:0]];
  logic        dev_pend = 1'b0;
  tl_d_op_e    dev_dop = AccessAck;
  logic [31:0] dev_rdata = 32'h0;
  logic [7:0]  dev_src = 8'h0;
  logic [1:0]  dev_size = 2'h0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic void tmo(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endfunction

  function automatic logic [7:0] src_of(input int h);
    return 8'(8'h10 + h);
  endfunction

  task automatic expect_txn(input int h, input tl_a_op_e op, input logic [31:0] addr,
                            input logic [31:0] wdata, input tl_d_op_e dop, input logic [31:0] rdata);
    exp_t e;
    e = '{host: h, op: op, addr: addr, wdata: wdata, dop: dop, rdata: rdata};
    exp_a.push_back(e);
    exp_d.push_back(e);
  endtask

  // One full host transaction: A beat, optional d_ready delay, D beat.
  task automatic host_txn(input int h, input tl_a_op_e op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int d_delay);
    int n;
    @(negedge clk); #1;
    bus.tl_h_i[h].a_valid   = 1'b1;
    bus.tl_h_i[h].a_opcode  = op;
    bus.tl_h_i[h].a_size    = 2'd2;
    bus.tl_h_i[h].a_source  = src_of(h);
    bus.tl_h_i[h].a_address = addr;
    bus.tl_h_i[h].a_mask    = 4'hF;
    bus.tl_h_i[h].a_data    = wdata;
    #2;
    n = 0;
    while (!bus.tl_h_o[h].a_ready && n < 300) begin
      @(negedge clk); #3;
      n++;
    end
    if (n >= 300) tmo("host a_ready wait");
    @(negedge clk); #1;
    bus.tl_h_i[h].a_valid = 1'b0;
    repeat (d_delay) begin
      @(negedge clk); #1;
    end
    bus.tl_h_i[h].d_ready = 1'b1;
    #2;
    n = 0;
    while (!bus.tl_h_o[h].d_valid && n < 300) begin
      @(negedge clk); #3;
      n++;
    end
    if (n >= 300) tmo("host d_valid wait");
    @(negedge clk); #1;
    bus.tl_h_i[h].d_ready = 1'b0;
  endtask

  task automatic host_loop(input int h, input int cnt);
    for (int j = 0; j < cnt; j++) begin
      host_txn(h, Get, 32'h100 + 32'(4 * h), 32'h0, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  // Device model: memory with one-cycle response, a_ready from dev_ar.
  initial begin
    mem[32'h100] = 32'h1111_1111;
    mem[32'h104] = 32'h2222_2222;
    mem[32'h108] = 32'h3333_3333;
    bus.tl_d_i = TL_D2H_IDLE;
    forever begin
      @(negedge clk); #1;
      if (!rst_ni) dev_pend = 1'b0;
      bus.tl_d_i.a_ready  = dev_ar;
      bus.tl_d_i.d_valid  = dev_pend;
      bus.tl_d_i.d_opcode = dev_dop;
      bus.tl_d_i.d_data   = dev_rdata;
      bus.tl_d_i.d_source = dev_src;
      bus.tl_d_i.d_size   = dev_size;
      #2;
      if (rst_ni) begin
        if (dev_pend && bus.tl_d_o.d_ready) dev_pend = 1'b0;
        if (bus.tl_d_o.a_valid && bus.tl_d_i.a_ready) begin
          dev_src  = bus.tl_d_o.a_source;
          dev_size = bus.tl_d_o.a_size;
          if (bus.tl_d_o.a_opcode == Get) begin
            dev_dop   = AccessAckData;
            dev_rdata = mem.exists(bus.tl_d_o.a_address) ? mem[bus.tl_d_o.a_address] : 32'hBAD0_BAD0;
          end else begin
            mem[bus.tl_d_o.a_address] = bus.tl_d_o.a_data;
            dev_dop   = AccessAck;
            dev_rdata = 32'h0;
          end
          dev_pend = 1'b1;
        end
      end
    end
  end

  // Monitor: compare every A beat reaching the device and every D beat
  // delivered to a host against the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk); #3;
      if (rst_ni) begin
        if (bus.tl_d_o.a_valid) av_cycles++;
        if (bus.tl_d_o.a_valid && bus.tl_d_i.a_ready) begin
          a_hs_cnt++;
          if (exp_a.size() == 0) begin
            tmo("unexpected A beat");
          end else begin
            mon_e = exp_a.pop_front();
            mon_oh = '0;
            mon_oh[mon_e.host] = 1'b1;
            check("A owner gnt", gnt, mon_oh);
            check("A address", bus.tl_d_o.a_address, mon_e.addr);
            check("A data", bus.tl_d_o.a_data, mon_e.wdata);
            check("A opcode", bus.tl_d_o.a_opcode, mon_e.op);
            check("A source", bus.tl_d_o.a_source, src_of(mon_e.host));
          end
        end
        for (int k = 0; k < N; k++) begin
          if (bus.tl_h_o[k].d_valid && bus.tl_h_i[k].d_ready) begin
            if (exp_d.size() == 0) begin
              tmo("unexpected D beat");
            end else begin
              mon_e = exp_d.pop_front();
              mon_oh = '0;
              mon_oh[mon_e.host] = 1'b1;
              check("D host", k, mon_e.host);
              check("D owner gnt", gnt, mon_oh);
              check("D opcode", bus.tl_h_o[k].d_opcode, mon_e.dop);
              check("D data", bus.tl_h_o[k].d_data, mon_e.rdata);
              check("D source", bus.tl_h_o[k].d_source, src_of(k));
            end
          end
          if (!gnt[k]) begin
            check("non-owner quiet", {bus.tl_h_o[k].a_ready, bus.tl_h_o[k].d_valid}, 2'b00);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_a;
    int base_v;
    int n;
    for (int k = 0; k < N; k++) bus.tl_h_i[k] = TL_H2D_IDLE;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("reset gnt", gnt, 3'b000);
    check("reset tl_d_o", bus.tl_d_o, TL_H2D_IDLE);
    for (int k = 0; k < N; k++) check("reset tl_h_o", bus.tl_h_o[k], TL_D2H_IDLE);
    @(negedge clk); #1;
    rst_ni = 1'b1;

    // Single host0 put, then read it back.
    base_a = a_hs_cnt;
    base_v = av_cycles;
    expect_txn(0, PutFullData, 32'h10, 32'hDEAD_BEEF, AccessAck, 32'h0);
    host_txn(0, PutFullData, 32'h10, 32'hDEAD_BEEF, 0);
    repeat (2) @(negedge clk);
    check("t1 a handshakes", a_hs_cnt - base_a, 1);
    check("t1 a_valid cycles", av_cycles - base_v, 1);
    expect_txn(0, Get, 32'h10, 32'h0, AccessAckData, 32'hDEAD_BEEF);
    host_txn(0, Get, 32'h10, 32'h0, 0);

    // Simultaneous host0/host1 right after reset: host0 first.
    do_reset();
    expect_txn(0, Get, 32'h100, 32'h0, AccessAckData, 32'h1111_1111);
    expect_txn(1, Get, 32'h104, 32'h0, AccessAckData, 32'h2222_2222);
    fork
      host_txn(0, Get, 32'h100, 32'h0, 0);
      host_txn(1, Get, 32'h104, 32'h0, 0);
    join
    // Host2 alone, so the pointer wraps back to host0 afterwards.
    expect_txn(2, Get, 32'h108, 32'h0, AccessAckData, 32'h3333_3333);
    host_txn(2, Get, 32'h108, 32'h0, 0);

    // Three back-to-back requests from each of three hosts.
    for (int j = 0; j < 3; j++) begin
      expect_txn(0, Get, 32'h100, 32'h0, AccessAckData, 32'h1111_1111);
      expect_txn(1, Get, 32'h104, 32'h0, AccessAckData, 32'h2222_2222);
      expect_txn(2, Get, 32'h108, 32'h0, AccessAckData, 32'h3333_3333);
    end
    fork
      host_loop(0, 3);
      host_loop(1, 3);
      host_loop(2, 3);
    join

    // Device stalls a_ready for 12 cycles with host1 also waiting.
    dev_ar = 1'b0;
    expect_txn(0, Get, 32'h100, 32'h0, AccessAckData, 32'h1111_1111);
    expect_txn(1, Get, 32'h104, 32'h0, AccessAckData, 32'h2222_2222);
    fork
      host_txn(0, Get, 32'h100, 32'h0, 0);
      host_txn(1, Get, 32'h104, 32'h0, 0);
      begin
        base_a = a_hs_cnt;
        n = 0;
        @(negedge clk); #3;
        while (gnt != 3'b001 && n < 50) begin
          @(negedge clk); #3;
          n++;
        end
        if (n >= 50) tmo("t4 grant wait");
        repeat (12) begin
          check("t4 stall gnt", gnt, 3'b001);
          check("t4 stall host a_ready", bus.tl_h_o[0].a_ready, 1'b0);
          check("t4 stall a_valid", bus.tl_d_o.a_valid, 1'b1);
          @(negedge clk); #3;
        end
        check("t4 no A during stall", a_hs_cnt - base_a, 0);
        @(negedge clk); #1;
        dev_ar = 1'b1;
      end
    join

    // Host2 holds d_ready low 5 cycles after the device responds.
    expect_txn(2, Get, 32'h108, 32'h0, AccessAckData, 32'h3333_3333);
    fork
      host_txn(2, Get, 32'h108, 32'h0, 5);
      begin
        n = 0;
        @(negedge clk); #3;
        while (!bus.tl_h_o[2].d_valid && n < 50) begin
          @(negedge clk); #3;
          n++;
        end
        if (n >= 50) tmo("t5 d_valid wait");
        repeat (5) begin
          check("t5 d_ready mirror low", bus.tl_d_o.d_ready, 1'b0);
          check("t5 data held", bus.tl_h_o[2].d_data, 32'h3333_3333);
          check("t5 gnt held", gnt, 3'b100);
          @(negedge clk); #3;
        end
        check("t5 d_ready mirror high", bus.tl_d_o.d_ready, 1'b1);
      end
    join
    @(negedge clk); #3;
    check("t5 back to idle", gnt, 3'b000);

    // Reset asserted while host0's response is pending.
    exp_a.push_back('{host: 0, op: Get, addr: 32'h100, wdata: 32'h0, dop: AccessAckData, rdata: 32'h1111_1111});
    @(negedge clk); #1;
    bus.tl_h_i[0].a_valid   = 1'b1;
    bus.tl_h_i[0].a_opcode  = Get;
    bus.tl_h_i[0].a_size    = 2'd2;
    bus.tl_h_i[0].a_source  = src_of(0);
    bus.tl_h_i[0].a_address = 32'h100;
    bus.tl_h_i[0].a_mask    = 4'hF;
    bus.tl_h_i[0].a_data    = 32'h0;
    #2;
    n = 0;
    while (!bus.tl_h_o[0].a_ready && n < 50) begin
      @(negedge clk); #3;
      n++;
    end
    if (n >= 50) tmo("t6 a_ready wait");
    @(negedge clk); #1;
    bus.tl_h_i[0].a_valid = 1'b0;
    #2;
    n = 0;
    while (!bus.tl_h_o[0].d_valid && n < 50) begin
      @(negedge clk); #3;
      n++;
    end
    if (n >= 50) tmo("t6 d_valid wait");
    check("t6 owner before reset", gnt, 3'b001);
    #1;
    rst_ni = 1'b0;
    bus.tl_h_i[0].d_ready = 1'b1;
    #2;
    for (int k = 0; k < N; k++) check("t6 reset d_valid", bus.tl_h_o[k].d_valid, 1'b0);
    check("t6 reset a_valid", bus.tl_d_o.a_valid, 1'b0);
    check("t6 reset d_ready", bus.tl_d_o.d_ready, 1'b0);
    check("t6 reset gnt", gnt, 3'b000);
    repeat (2) @(negedge clk);
    #1;
    bus.tl_h_i[0].d_ready = 1'b0;
    @(negedge clk); #1;
    rst_ni = 1'b1;
    expect_txn(1, Get, 32'h104, 32'h0, AccessAckData, 32'h2222_2222);
    host_txn(1, Get, 32'h104, 32'h0, 0);

    repeat (3) @(negedge clk);
    check("A queue drained", exp_a.size(), 0);
    check("D queue drained", exp_d.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
